// File: rtl/count_sequencer_if.sv
// Command channel of the LED counter sequencer: a single valid/ready handshake
// carrying a 2-bit opcode and a CNT_W-bit load value.
interface count_sequencer_if #(
  parameter int CNT_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_data;

  // The command source drives valid/op/data and watches ready.
  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  // The sequencer consumes commands and reports when it can take one.
  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface : count_sequencer_if

// File: rtl/count_sequencer.sv
// Run/stop/load controller for the LED counter datapath.
// A clock-enable prescaler replaces the old derived slow clock: while running,
// cnt_en pulses for one board-clock cycle every DIV_MAX+1 cycles. Commands
// arrive on a valid/ready channel; the counter value is fed back on count_in
// so that wrap-arounds can be tallied in wrap_cnt (saturating at 255).
module count_sequencer #(
  parameter int          CNT_W   = 4,
  parameter int          DIV_W   = 26,
  parameter int unsigned DIV_MAX = 67108863
) (
  input  logic             clk,
  input  logic             clr,
  count_sequencer_if.slave cmd,
  input  logic [CNT_W-1:0] count_in,
  output logic             cnt_en,
  output logic             cnt_dir,
  output logic             cnt_load,
  output logic [CNT_W-1:0] cnt_val,
  output logic [7:0]       wrap_cnt,
  output logic [1:0]       state
);

  // Encodings are visible on the state port, so they are pinned explicitly.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LOAD = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_START_UP   = 2'b00,
    OP_START_DOWN = 2'b01,
    OP_STOP       = 2'b10,
    OP_LOAD       = 2'b11
  } op_t;

  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_TOP  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_BOT  = '0;
  localparam logic [7:0]       WRAP_SAT = 8'hFF;

  // Registered state and its next-state companions.
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             en_q, en_d;
  logic             load_q, load_d;
  logic [CNT_W-1:0] val_q, val_d;
  logic             dir_q, dir_d;
  logic [7:0]       wrap_q, wrap_d;

  // Decoded command and side conditions.
  op_t  op;
  logic accept;
  logic is_start;
  logic terminal;
  logic wrap_hit;

  // Ready drops only for the single LOAD cycle; decoded straight from state.
  assign cmd.cmd_ready = (state_q != ST_LOAD);

  assign op       = op_t'(cmd.cmd_op);
  assign accept   = cmd.cmd_valid && cmd.cmd_ready;
  assign is_start = (op == OP_START_UP) || (op == OP_START_DOWN);
  assign terminal = (div_q == DIV_TERM);

  // A step taken this cycle wraps if it leaves the end of the range in the
  // direction currently being counted.
  assign wrap_hit = en_q && (dir_q ? (count_in == CNT_TOP) : (count_in == CNT_BOT));

  // Next-state and next-output decode for the controller.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    state_d = state_q;
    div_d   = div_q;
    en_d    = 1'b0;
    load_d  = 1'b0;
    val_d   = val_q;
    dir_d   = dir_q;
    wrap_d  = (wrap_hit && (wrap_q != WRAP_SAT)) ? wrap_q + 8'd1 : wrap_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_start) begin
            // Fresh start: prescaler phase and wrap tally both begin at zero.
            state_d = ST_RUN;
            dir_d   = (op == OP_START_UP);
            div_d   = '0;
            wrap_d  = '0;
          end else if (op == OP_LOAD) begin
            state_d = ST_LOAD;
            load_d  = 1'b1;
            val_d   = cmd.cmd_data;
          end
          // STOP while idle changes nothing.
        end
      end

      ST_RUN: begin
        // Free-running prescaler; the step pulse is registered, so it appears
        // in the cycle after the terminal count.
        div_d = terminal ? '0 : div_q + DIV_ONE;
        en_d  = terminal;
        if (accept) begin
          if (is_start) begin
            // Direction change only; phase and tally continue undisturbed.
            dir_d = (op == OP_START_UP);
          end else if (op == OP_STOP) begin
            // STOP beats a coincident terminal count.
            state_d = ST_IDLE;
            div_d   = '0;
            en_d    = 1'b0;
          end else begin
            // LOAD likewise swallows a coincident step, keeping cnt_en and
            // cnt_load mutually exclusive.
            state_d = ST_LOAD;
            div_d   = '0;
            en_d    = 1'b0;
            load_d  = 1'b1;
            val_d   = cmd.cmd_data;
          end
        end
      end

      ST_LOAD: begin
        // One-cycle load strobe, then wait for a new START.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
      end
    endcase
  end

  // State and output registers; clr aborts any run or load at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      en_q    <= 1'b0;
      load_q  <= 1'b0;
      val_q   <= '0;
      dir_q   <= 1'b1;
      wrap_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q <= state_d;
      div_q   <= div_d;
      en_q    <= en_d;
      load_q  <= load_d;
      val_q   <= val_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  assign state    = state_q;
  assign cnt_en   = en_q;
  assign cnt_load = load_q;
  assign cnt_val  = val_q;
  assign cnt_dir  = dir_q;
  assign wrap_cnt = wrap_q;

  // The counter must never be asked to step and load in the same cycle.
  a_en_load_excl : assert property (@(posedge clk) disable iff (clr)
    !(cnt_en && cnt_load));

  // The load strobe is a single-cycle pulse.
  a_load_single : assert property (@(posedge clk) disable iff (clr)
    cnt_load |=> !cnt_load);

endmodule : count_sequencer

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer with a short prescaler (DIV_MAX=3):
// a hand-computed vector table, hand-written corner sequences, then random
// commands checked against a behavioural model.
module tb_count_sequencer;

  localparam int PERIOD = 4;  // DIV_MAX+1

  localparam logic [1:0] OP_UP   = 2'd0;
  localparam logic [1:0] OP_DOWN = 2'd1;
  localparam logic [1:0] OP_STOP = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] count_in;
  logic       cnt_en, cnt_dir, cnt_load;
  logic [3:0] cnt_val;
  logic [7:0] wrap_cnt;
  logic [1:0] state;

  count_sequencer_if #(.CNT_W(4)) cmd_if ();

  count_sequencer #(.CNT_W(4), .DIV_W(4), .DIV_MAX(3)) dut (
    .clk      (clk),
    .clr      (clr),
    .cmd      (cmd_if),
    .count_in (count_in),
    .cnt_en   (cnt_en),
    .cnt_dir  (cnt_dir),
    .cnt_load (cnt_load),
    .cnt_val  (cnt_val),
    .wrap_cnt (wrap_cnt),
    .state    (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counting is described by the age (edges since the
  // START that began the run); the counter steps whenever age is a positive
  // multiple of the prescale period.
  int         m_state;   // 0 idle, 1 run, 2 load
  int         m_age;
  int         m_wrap;
  bit         m_en, m_load, m_dir;
  logic [3:0] m_val;

  task automatic model_reset();
    m_state = 0; m_age = 0; m_wrap = 0;
    m_en = 0; m_load = 0; m_dir = 1; m_val = '0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] op,
                            input logic [3:0] d, input logic [3:0] cin);
    bit acc, fresh;
    acc   = v && (m_state != 2);
    fresh = 0;
    if (m_en && (cin == (m_dir ? 4'hF : 4'h0)) && m_wrap < 255) m_wrap++;
    m_load = 0;
    if (m_state == 2) begin
      m_state = 0;
    end else if (acc) begin
      case (op)
        OP_UP, OP_DOWN: begin
          if (m_state == 0) begin
            m_state = 1; fresh = 1; m_wrap = 0;
          end
          m_dir = (op == OP_UP);
        end
        OP_STOP: m_state = 0;
        default: begin m_state = 2; m_load = 1; m_val = d; end
      endcase
    end
    if (m_state == 1) m_age = fresh ? 0 : m_age + 1;
    m_en = (m_state == 1) && (m_age > 0) && (m_age % PERIOD == 0);
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_state"}, 32'(state),    32'(m_state));
    check({tag, "_en"},    32'(cnt_en),   32'(m_en));
    check({tag, "_load"},  32'(cnt_load), 32'(m_load));
    check({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'(m_state != 2));
    check({tag, "_dir"},   32'(cnt_dir),  32'(m_dir));
    check({tag, "_wrap"},  32'(wrap_cnt), 32'(m_wrap));
    check({tag, "_val"},   32'(cnt_val),  32'(m_val));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(state),    32'd0);
    check({tag, "_en"},    32'(cnt_en),   32'd0);
    check({tag, "_load"},  32'(cnt_load), 32'd0);
    check({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
    check({tag, "_dir"},   32'(cnt_dir),  32'd1);
    check({tag, "_wrap"},  32'(wrap_cnt), 32'd0);
    check({tag, "_val"},   32'(cnt_val),  32'd0);
  endtask

  // One clock cycle: drive at the negedge, model follows the posedge,
  // outputs are then stable for checking at the next negedge.
  task automatic cycle(input logic v, input logic [1:0] op,
                       input logic [3:0] d, input logic [3:0] cin);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = d;
    count_in         = cin;
    @(posedge clk);
    model_step(v, op, d, cin);
    @(negedge clk);
  endtask

  // Asynchronous clear raised mid-cycle with a START pending; must take effect
  // without waiting for a clock and hold everything quiet while asserted.
  task automatic pulse_clr(input string tag, input int hold);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_UP;
    clr = 1'b1;
    #1;
    check_reset({tag, "_now"});
    model_reset();
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_en"},    32'(cnt_en), 32'd0);
      check({tag, "_hold_state"}, 32'(state),  32'd0);
    end
    clr = 1'b0;
    cmd_if.cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [3:0] d;
    logic [3:0] cin;
    logic [1:0] st;
    logic       en;
    logic       ld;
    logic       rdy;
    logic       dir;
    logic [7:0] wrap;
    logic [3:0] val;
  } vec_t;

  function automatic vec_t vec(input logic v, input logic [1:0] op, input logic [3:0] d,
                               input logic [3:0] cin, input logic [1:0] st, input logic en,
                               input logic ld, input logic rdy, input logic dir,
                               input logic [7:0] wrap, input logic [3:0] val);
    vec_t r;
    r.v = v; r.op = op; r.d = d; r.cin = cin; r.st = st; r.en = en;
    r.ld = ld; r.rdy = rdy; r.dir = dir; r.wrap = wrap; r.val = val;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   last, pulses;

    // Row = inputs for one cycle and the outputs expected after that edge.
    tbl.push_back(vec(1, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 1, 8'd0, 4'h0)); // start, age0
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 1, 8'd0, 4'h0));
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 1, 8'd0, 4'h0));
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 1, 8'd0, 4'h0));
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 1, 0, 1, 1, 8'd0, 4'h0)); // first step
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'hF, 2'd1, 0, 0, 1, 1, 8'd1, 4'h0)); // up wrap
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 1, 8'd1, 4'h0));
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 1, 8'd1, 4'h0));
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 1, 0, 1, 1, 8'd1, 4'h0)); // age8 step
    tbl.push_back(vec(1, OP_DOWN, 4'h0, 4'hF, 2'd1, 0, 0, 1, 0, 8'd2, 4'h0)); // dir flip in run
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h5, 2'd1, 0, 0, 1, 0, 8'd2, 4'h0));
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 0, 8'd2, 4'h0));
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 1, 0, 1, 0, 8'd2, 4'h0)); // spacing kept
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 0, 8'd3, 4'h0)); // down wrap
    tbl.push_back(vec(1, OP_LOAD, 4'hA, 4'h0, 2'd2, 0, 1, 0, 0, 8'd3, 4'hA)); // load from run
    tbl.push_back(vec(1, OP_UP,   4'h0, 4'h0, 2'd0, 0, 0, 1, 0, 8'd3, 4'hA)); // held start ignored
    tbl.push_back(vec(1, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 1, 8'd0, 4'hA)); // accepted in idle
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 1, 8'd0, 4'hA));
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 1, 8'd0, 4'hA));
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 1, 8'd0, 4'hA));
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 1, 0, 1, 1, 8'd0, 4'hA)); // 4 cycles later
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h3, 2'd1, 0, 0, 1, 1, 8'd0, 4'hA));
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 1, 8'd0, 4'hA));
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd1, 0, 0, 1, 1, 8'd0, 4'hA)); // terminal next
    tbl.push_back(vec(1, OP_STOP, 4'h0, 4'h0, 2'd0, 0, 0, 1, 1, 8'd0, 4'hA)); // stop wins
    tbl.push_back(vec(0, OP_UP,   4'h0, 4'h0, 2'd0, 0, 0, 1, 1, 8'd0, 4'hA));
    tbl.push_back(vec(1, OP_STOP, 4'h0, 4'h0, 2'd0, 0, 0, 1, 1, 8'd0, 4'hA)); // stop in idle

    // Reset with a command pending: it must be ignored.
    clr = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_UP;
    cmd_if.cmd_data  = 4'h7;
    count_in         = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset");
    clr = 1'b0;
    cmd_if.cmd_valid = 1'b0;

    // Table-driven directed vectors.
    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cycle(tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].cin);
      check({tag, "_state"}, 32'(state),    32'(tbl[i].st));
      check({tag, "_en"},    32'(cnt_en),   32'(tbl[i].en));
      check({tag, "_load"},  32'(cnt_load), 32'(tbl[i].ld));
      check({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'(tbl[i].rdy));
      check({tag, "_dir"},   32'(cnt_dir),  32'(tbl[i].dir));
      check({tag, "_wrap"},  32'(wrap_cnt), 32'(tbl[i].wrap));
      check({tag, "_val"},   32'(cnt_val),  32'(tbl[i].val));
    end

    // clr raised during a step pulse in a down run with a nonzero tally.
    cycle(1, OP_DOWN, 4'h0, 4'h0);
    for (int k = 0; k < 2 * PERIOD; k++) begin
      cycle(0, OP_UP, 4'h0, 4'h0);
      compare_model("t1_run");
    end
    check("t1_pulse_before_clr", 32'(cnt_en), 32'd1);
    check("t1_wrap_before_clr",  32'(wrap_cnt), 32'd1);
    pulse_clr("t1_clr", 2 * PERIOD);

    // LOAD accepted on the terminal-count cycle suppresses the step.
    cycle(1, OP_UP, 4'h0, 4'h0);
    for (int k = 0; k < PERIOD - 1; k++) cycle(0, OP_UP, 4'h0, 4'h0);
    cycle(1, OP_LOAD, 4'h5, 4'h0);
    check("tl_en",    32'(cnt_en),   32'd0);
    check("tl_load",  32'(cnt_load), 32'd1);
    check("tl_state", 32'(state),    32'd2);
    check("tl_val",   32'(cnt_val),  32'h5);
    check("tl_ready", 32'(cmd_if.cmd_ready), 32'd0);
    cycle(0, OP_UP, 4'h0, 4'h0);
    check("tl_after_state", 32'(state),    32'd0);
    check("tl_after_load",  32'(cnt_load), 32'd0);
    compare_model("tl_after");

    // Long down run with count_in stuck at 0: tally saturates, spacing holds.
    cycle(1, OP_UP, 4'h0, 4'h0);
    last   = -1;
    pulses = 0;
    for (int c = 0; c < 1400 && pulses < 300; c++) begin
      if (c == 6) cycle(1, OP_DOWN, 4'h0, 4'h0);
      else        cycle(0, OP_UP, 4'h0, 4'h0);
      compare_model("t5");
      if (c == 6) check("t5_dir_next", 32'(cnt_dir), 32'd0);
      if (cnt_en) begin
        pulses++;
        if (last >= 0) check("t5_spacing", 32'(c - last), 32'(PERIOD));
        last = c;
      end
    end
    check("t5_pulses",   32'(pulses),   32'd300);
    check("t5_wrap_sat", 32'(wrap_cnt), 32'd255);
    cycle(1, OP_STOP, 4'h0, 4'h0);
    compare_model("t5_stop");

    // Random commands against the model, with occasional clears.
    for (int n = 0; n < 2000; n++) begin
      logic       v;
      logic [1:0] op;
      logic [3:0] d, cin;
      if ($urandom_range(0, 199) == 0) begin
        pulse_clr("rnd_clr", 1 + $urandom_range(0, 2));
      end else begin
        v   = ($urandom_range(0, 9) < 4);
        op  = 2'($urandom);
        d   = 4'($urandom);
        cin = ($urandom_range(0, 1) != 0) ? (($urandom_range(0, 1) != 0) ? 4'hF : 4'h0)
                                          : 4'($urandom);
        cycle(v, op, d, cin);
        compare_model("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_count_sequencer
